// File: rtl/dcm_rst_ctrl_pkg.sv
// rtl/dcm_rst_ctrl_pkg.sv - state encodings and sizing helpers for the DCM reset controller
package dcm_rst_ctrl_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_HOLD      = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_t;

    // One counter serves every timed state, so it is sized for the longest interval.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/dcm_rst_ctrl_sync_2ff.sv
// rtl/dcm_rst_ctrl_sync_2ff.sv - two-flop synchronizer for a single asynchronous input
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/dcm_rst_ctrl.sv
// rtl/dcm_rst_ctrl.sv - DCM reset pulse, lock watchdog with bounded retries, debounced ready
module dcm_rst_ctrl
    import dcm_rst_ctrl_pkg::*;
#(
    parameter int RST_CYCLES    = 4,
    parameter int LOCK_TIMEOUT  = 2048,
    parameter int STABLE_CYCLES = 64,
    parameter int MAX_RETRIES   = 7,
    localparam int RETRY_W      = $clog2(MAX_RETRIES + 1)
) (
    input  logic               clk11,
    input  logic               rst,
    input  logic               locked,
    output logic               dcm_rst,
    output logic               ready,
    output logic               lock_lost,
    output logic               fail,
    output logic [RETRY_W-1:0] retries
);

    localparam int CNT_W = cnt_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);

    localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRIES);

    logic               locked_s;
    state_t             state_q, state_n;
    logic [CNT_W-1:0]   cnt_q, cnt_n;
    logic [RETRY_W-1:0] retries_n;
    logic               lock_lost_n;

    sync_2ff u_lock_sync (
        .clk (clk11),
        .rst (rst),
        .d   (locked),
        .q   (locked_s)
    );

    always_ff @(posedge clk11 or posedge rst) begin
        if (rst) begin
            state_q   <= ST_HOLD;
            cnt_q     <= '0;
            retries   <= '0;
            dcm_rst   <= 1'b1;
            ready     <= 1'b0;
            lock_lost <= 1'b0;
            fail      <= 1'b0;
        end else begin
            state_q   <= state_n;
            cnt_q     <= cnt_n;
            retries   <= retries_n;
            // Outputs are decoded from the next state so they change on the same edge as the state.
            dcm_rst   <= (state_n == ST_HOLD) || (state_n == ST_FAIL);
            ready     <= (state_n == ST_RUN);
            lock_lost <= lock_lost_n;
            fail      <= (state_n == ST_FAIL);
        end
    end

    always_comb begin
        state_n     = state_q;
        cnt_n       = cnt_q;
        retries_n   = retries;
        lock_lost_n = 1'b0;
        case (state_q)
            ST_HOLD: begin
                if (cnt_q == RST_LAST) begin
                    state_n = ST_WAIT_LOCK;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            ST_WAIT_LOCK: begin
                // A lock seen on the final timeout cycle still wins over the retry.
                if (locked_s) begin
                    state_n = ST_STABLE;
                    cnt_n   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    cnt_n = '0;
                    if (retries == RETRY_MAX) begin
                        state_n = ST_FAIL;
                    end else begin
                        retries_n = retries + 1'b1;
                        state_n   = ST_HOLD;
                    end
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            ST_STABLE: begin
                if (!locked_s) begin
                    state_n = ST_WAIT_LOCK;
                    cnt_n   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_n   = ST_RUN;
                    cnt_n     = '0;
                    retries_n = '0;
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (!locked_s) begin
                    state_n     = ST_HOLD;
                    cnt_n       = '0;
                    lock_lost_n = 1'b1;
                end
            end
            ST_FAIL: begin
                cnt_n = '0;
            end
            default: begin
                state_n = ST_HOLD;
                cnt_n   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_dcm_rst_ctrl.sv
// tb/tb_dcm_rst_ctrl.sv - directed self-checking bench for dcm_rst_ctrl
module tb_dcm_rst_ctrl;

    logic       clk11;
    logic       rst;
    logic       locked;
    logic       dcm_rst;
    logic       ready;
    logic       lock_lost;
    logic       fail;
    logic [1:0] retries;

    int n_checks;
    int n_fail;
    int cyc;

    dcm_rst_ctrl #(
        .RST_CYCLES    (4),
        .LOCK_TIMEOUT  (32),
        .STABLE_CYCLES (8),
        .MAX_RETRIES   (2)
    ) dut (
        .clk11     (clk11),
        .rst       (rst),
        .locked    (locked),
        .dcm_rst   (dcm_rst),
        .ready     (ready),
        .lock_lost (lock_lost),
        .fail      (fail),
        .retries   (retries)
    );

    initial clk11 = 1'b0;
    always #5 clk11 = ~clk11;

    // Edge k is the k-th rising clock edge after rst release; values are sampled 1 ns after it.
    task automatic goto_edge(input int k);
        while (cyc < k) begin
            @(posedge clk11);
            #1;
            cyc++;
        end
    endtask

    task automatic hold_reset();
        rst    = 1'b1;
        locked = 1'b0;
        repeat (3) @(posedge clk11);
        #1;
    endtask

    task automatic release_reset();
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic test_reset();
        hold_reset();
        n_checks++;
        if ({dcm_rst, ready, lock_lost, fail, retries} !== 6'b100000) begin
            n_fail++;
            $display("FAIL reset_values: got %b expected 100000",
                     {dcm_rst, ready, lock_lost, fail, retries});
        end
    endtask

    task automatic run_power_up(input string tag);
        release_reset();
        n_checks++;
        if (dcm_rst !== 1'b1) begin
            n_fail++;
            $display("FAIL %s dcm_rst_cycle0: got %b expected 1", tag, dcm_rst);
        end
        goto_edge(3);
        n_checks++;
        if (dcm_rst !== 1'b1) begin
            n_fail++;
            $display("FAIL %s dcm_rst_edge3: got %b expected 1", tag, dcm_rst);
        end
        goto_edge(4);
        n_checks++;
        if (dcm_rst !== 1'b0) begin
            n_fail++;
            $display("FAIL %s dcm_rst_edge4: got %b expected 0", tag, dcm_rst);
        end
        goto_edge(9);
        locked = 1'b1;
        goto_edge(19);
        n_checks++;
        if (ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s ready_edge19: got %b expected 0", tag, ready);
        end
        goto_edge(20);
        n_checks++;
        if ({ready, dcm_rst, fail, retries} !== 5'b10000) begin
            n_fail++;
            $display("FAIL %s run_edge20: got %b expected 10000", tag,
                     {ready, dcm_rst, fail, retries});
        end
    endtask

    task automatic test_power_up();
        hold_reset();
        run_power_up("power_up");
    endtask

    task automatic test_timeout_retry();
        int         edges [13] = '{3, 4, 35, 36, 39, 40, 71, 72, 75, 76, 107, 108, 120};
        logic [4:0] expv  [13] = '{5'b10000, 5'b00000, 5'b00000, 5'b10001, 5'b10001,
                                   5'b00001, 5'b00001, 5'b10010, 5'b10010, 5'b00010,
                                   5'b00010, 5'b10110, 5'b10110};
        hold_reset();
        release_reset();
        for (int i = 0; i < 13; i++) begin
            goto_edge(edges[i]);
            n_checks++;
            if ({dcm_rst, ready, fail, retries} !== expv[i]) begin
                n_fail++;
                $display("FAIL timeout_edge%0d {dcm_rst,ready,fail,retries}: got %b expected %b",
                         edges[i], {dcm_rst, ready, fail, retries}, expv[i]);
            end
        end
    endtask

    task automatic test_glitch_in_stable();
        logic seen_lost;
        seen_lost = 1'b0;
        hold_reset();
        release_reset();
        for (int k = 1; k <= 27; k++) begin
            goto_edge(k);
            if (lock_lost) seen_lost = 1'b1;
            if (k == 9)  locked = 1'b1;
            if (k == 15) locked = 1'b0;
            if (k == 16) locked = 1'b1;
            if (k == 20 || k == 26) begin
                n_checks++;
                if (ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL glitch ready_edge%0d: got %b expected 0", k, ready);
                end
            end
        end
        n_checks++;
        if ({ready, retries} !== 3'b100) begin
            n_fail++;
            $display("FAIL glitch run_edge27 {ready,retries}: got %b expected 100", {ready, retries});
        end
        n_checks++;
        if (seen_lost !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch lock_lost_seen: got %b expected 0", seen_lost);
        end
    endtask

    task automatic test_lock_drop();
        hold_reset();
        run_power_up("lock_drop_setup");
        goto_edge(24);
        locked = 1'b0;
        goto_edge(26);
        n_checks++;
        if ({ready, lock_lost, dcm_rst} !== 3'b100) begin
            n_fail++;
            $display("FAIL drop_edge26 {ready,lock_lost,dcm_rst}: got %b expected 100",
                     {ready, lock_lost, dcm_rst});
        end
        goto_edge(27);
        locked = 1'b1;
        n_checks++;
        if ({ready, lock_lost, dcm_rst} !== 3'b011) begin
            n_fail++;
            $display("FAIL drop_edge27 {ready,lock_lost,dcm_rst}: got %b expected 011",
                     {ready, lock_lost, dcm_rst});
        end
        goto_edge(28);
        n_checks++;
        if ({lock_lost, dcm_rst} !== 2'b01) begin
            n_fail++;
            $display("FAIL drop_edge28 {lock_lost,dcm_rst}: got %b expected 01", {lock_lost, dcm_rst});
        end
        goto_edge(30);
        n_checks++;
        if (dcm_rst !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_edge30 dcm_rst: got %b expected 1", dcm_rst);
        end
        goto_edge(31);
        n_checks++;
        if (dcm_rst !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_edge31 dcm_rst: got %b expected 0", dcm_rst);
        end
        goto_edge(39);
        n_checks++;
        if (ready !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_edge39 ready: got %b expected 0", ready);
        end
        goto_edge(40);
        n_checks++;
        if ({ready, retries} !== 3'b100) begin
            n_fail++;
            $display("FAIL drop_relock_edge40 {ready,retries}: got %b expected 100", {ready, retries});
        end
    endtask

    task automatic test_lock_on_timeout();
        hold_reset();
        release_reset();
        goto_edge(33);
        locked = 1'b1;
        goto_edge(36);
        n_checks++;
        if ({dcm_rst, retries} !== 3'b000) begin
            n_fail++;
            $display("FAIL exact_timeout_edge36 {dcm_rst,retries}: got %b expected 000",
                     {dcm_rst, retries});
        end
        goto_edge(37);
        n_checks++;
        if (dcm_rst !== 1'b0) begin
            n_fail++;
            $display("FAIL exact_timeout_edge37 dcm_rst: got %b expected 0", dcm_rst);
        end
        goto_edge(43);
        n_checks++;
        if (ready !== 1'b0) begin
            n_fail++;
            $display("FAIL exact_timeout_edge43 ready: got %b expected 0", ready);
        end
        goto_edge(44);
        n_checks++;
        if ({ready, retries} !== 3'b100) begin
            n_fail++;
            $display("FAIL exact_timeout_edge44 {ready,retries}: got %b expected 100", {ready, retries});
        end
    endtask

    task automatic test_async_abort();
        hold_reset();
        release_reset();
        goto_edge(9);
        locked = 1'b1;
        goto_edge(14);
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({dcm_rst, ready, lock_lost, fail, retries} !== 6'b100000) begin
            n_fail++;
            $display("FAIL abort_stable outputs: got %b expected 100000",
                     {dcm_rst, ready, lock_lost, fail, retries});
        end
        hold_reset();
        run_power_up("restart_after_stable");

        hold_reset();
        release_reset();
        goto_edge(110);
        n_checks++;
        if ({fail, retries} !== 3'b110) begin
            n_fail++;
            $display("FAIL abort_fail_setup {fail,retries}: got %b expected 110", {fail, retries});
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({dcm_rst, ready, lock_lost, fail, retries} !== 6'b100000) begin
            n_fail++;
            $display("FAIL abort_fail outputs: got %b expected 100000",
                     {dcm_rst, ready, lock_lost, fail, retries});
        end
        hold_reset();
        run_power_up("restart_after_fail");
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        rst      = 1'b1;
        locked   = 1'b0;
        test_reset();
        test_power_up();
        test_timeout_retry();
        test_glitch_in_stable();
        test_lock_drop();
        test_lock_on_timeout();
        test_async_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
